// File: rtl/cpu_uart_top_pkg.sv
// Shared RV32I-subset encodings, ALU op set and the built-in boot image.
// Pure definitions; no timing or flow control.
package cpu_uart_top_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
  } alu_op_t;

  // addi x1,x0,0x12 ; sw x1,0(x0) ; jal x0,0
  localparam logic [31:0] BOOT_W0 = 32'h0120_0093;
  localparam logic [31:0] BOOT_W1 = 32'h0010_2023;
  localparam logic [31:0] BOOT_W2 = 32'h0000_006F;

  function automatic logic [31:0] boot_word(input int idx);
    case (idx)
      0:       return BOOT_W0;
      1:       return BOOT_W1;
      2:       return BOOT_W2;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_uart_top_data_mem.sv
// Word-addressed data RAM: combinational read, write on the rising edge.
// Latency: read 0 cycles, write 1 edge; no backpressure. Contents survive reset.
module cpu_uart_top_data_mem #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        wr_vld,
  input  logic [29:0] word_addr,
  input  logic [31:0] wr_dat,
  output logic [31:0] rd_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   ram [0:DEPTH-1] = '{default: '0};
  logic [AW-1:0] idx;

  assign idx = AW'(word_addr % 30'(DEPTH));

  always_ff @(posedge clk)
    if (wr_vld) ram[idx] <= wr_dat;

  assign rd_dat = ram[idx];

endmodule

// File: rtl/cpu_uart_top.sv
// Boot loader plus single-cycle RV32I-subset core; one instruction per clock after load.
// Latency: LOAD_WORDS load cycles after reset, then results commit on the next edge; no backpressure.
module cpu_uart_top
  import cpu_uart_top_pkg::*;
#(
  parameter int    LOAD_WORDS = 3,
  parameter int    IMEM_WORDS = 256,
  parameter int    DMEM_WORDS = 256,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] alu_result,
  output logic [31:0] pc
);
  localparam int CW  = $clog2(LOAD_WORDS + 1);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam logic [0:0] PH_LOAD = 1'b0;
  localparam logic [0:0] PH_RUN  = 1'b1;

  logic [0:0]    phase;
  logic [CW-1:0] cnt;
  logic [31:0]   boot_dat;
  logic [31:0]   imem [0:IMEM_WORDS-1] = '{default: '0};
  logic [31:0]   regs [0:31];

  assign boot_dat = boot_word(int'(cnt));

  always_ff @(posedge clk)
    if (!rst && phase == PH_LOAD) imem[IAW'(cnt)] <= boot_dat;

  logic [31:0] instr, imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val, pc_plus4;

  assign instr    = imem[IAW'(pc[31:2] % 30'(IMEM_WORDS))];
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7   = instr[31:25];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u    = {instr[31:12], 12'h000};
  assign rs1_val  = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
  assign pc_plus4 = pc + 32'd4;

  alu_op_t     alu_op;
  logic [31:0] alu_a, alu_b, alu_out, wb_dat, next_pc, mem_rd_dat;
  logic        reg_we, mem_we, is_load, is_jalr;

  always_comb begin
    alu_op  = ALU_ADD;
    alu_a   = rs1_val;
    alu_b   = rs2_val;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    is_load = 1'b0;
    is_jalr = 1'b0;
    next_pc = pc_plus4;
    case (opcode)
      OP_LUI: begin
        alu_op = ALU_PASSB;
        alu_b  = imm_u;
        reg_we = 1'b1;
      end
      OP_IMM: begin
        alu_b  = imm_i;
        reg_we = 1'b1;
        case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_SLT:  alu_op = ALU_SLT;
          F3_XOR:  alu_op = ALU_XOR;
          F3_OR:   alu_op = ALU_OR;
          F3_AND:  alu_op = ALU_AND;
          default: reg_we = 1'b0;
        endcase
      end
      OP_REG: begin
        reg_we = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}:  alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD}:  alu_op = ALU_SUB;
          {F7_BASE, F3_SLL}:  alu_op = ALU_SLL;
          {F7_BASE, F3_SLT}:  alu_op = ALU_SLT;
          {F7_BASE, F3_SLTU}: alu_op = ALU_SLTU;
          {F7_BASE, F3_XOR}:  alu_op = ALU_XOR;
          {F7_BASE, F3_SR}:   alu_op = ALU_SRL;
          {F7_ALT,  F3_SR}:   alu_op = ALU_SRA;
          {F7_BASE, F3_OR}:   alu_op = ALU_OR;
          {F7_BASE, F3_AND}:  alu_op = ALU_AND;
          default:            reg_we = 1'b0;
        endcase
      end
      OP_LOAD: begin
        alu_b   = imm_i;
        is_load = (funct3 == F3_WORD);
        reg_we  = is_load;
      end
      OP_STORE: begin
        alu_b  = imm_s;
        mem_we = (funct3 == F3_WORD);
      end
      OP_BRANCH: begin
        alu_op = ALU_SUB;
        case (funct3)
          F3_BEQ:  if (rs1_val == rs2_val) next_pc = pc + imm_b;
          F3_BNE:  if (rs1_val != rs2_val) next_pc = pc + imm_b;
          F3_BLT:  if ($signed(rs1_val) <  $signed(rs2_val)) next_pc = pc + imm_b;
          F3_BGE:  if ($signed(rs1_val) >= $signed(rs2_val)) next_pc = pc + imm_b;
          default: next_pc = pc_plus4;
        endcase
      end
      OP_JAL: begin
        alu_a   = pc;
        alu_b   = 32'd4;
        reg_we  = 1'b1;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == F3_ADD) begin
          alu_b   = imm_i;
          reg_we  = 1'b1;
          is_jalr = 1'b1;
        end
      end
      default: ;
    endcase
    if (is_jalr) next_pc = alu_out & ~32'd1;
  end

  always_comb begin
    unique case (alu_op)
      ALU_ADD:   alu_out = alu_a + alu_b;
      ALU_SUB:   alu_out = alu_a - alu_b;
      ALU_AND:   alu_out = alu_a & alu_b;
      ALU_OR:    alu_out = alu_a | alu_b;
      ALU_XOR:   alu_out = alu_a ^ alu_b;
      ALU_SLT:   alu_out = {31'h0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  alu_out = {31'h0, alu_a < alu_b};
      ALU_SLL:   alu_out = alu_a << alu_b[4:0];
      ALU_SRL:   alu_out = alu_a >> alu_b[4:0];
      ALU_SRA:   alu_out = $signed(alu_a) >>> alu_b[4:0];
      ALU_PASSB: alu_out = alu_b;
      default:   alu_out = 32'h0;
    endcase
  end

  // JALR links pc+4 while the ALU carries the jump target
  assign wb_dat     = is_load ? mem_rd_dat : (is_jalr ? pc_plus4 : alu_out);
  assign alu_result = (phase == PH_RUN) ? alu_out : 32'h0;

  cpu_uart_top_data_mem #(.DEPTH(DMEM_WORDS)) data_mem (
    .clk       (clk),
    .wr_vld    (mem_we && phase == PH_RUN),
    .word_addr (alu_out[31:2]),
    .wr_dat    (rs2_val),
    .rd_dat    (mem_rd_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= 32'h0;
      cnt   <= '0;
      phase <= PH_LOAD;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (phase == PH_LOAD) begin
      cnt <= cnt + 1'b1;
      if (cnt == CW'(LOAD_WORDS - 1)) phase <= PH_RUN;
    end else begin
      pc <= next_pc;
      if (reg_we && rd != 5'd0) regs[rd] <= wb_dat;
    end
  end

endmodule

// File: tb/tb_cpu_uart_top.sv
// Scoreboarded bench: expected (pc, alu_result) traces queued per program, popped each cycle.
// Programs are patched into imem after the default image parks in its halt loop.
module tb_cpu_uart_top;
  logic        clk;
  logic        rst;
  logic [31:0] alu_result;
  logic [31:0] pc;

  cpu_uart_top dut (.clk(clk), .rst(rst), .alu_result(alu_result), .pc(pc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] O_IMM = 7'h13, O_REG = 7'h33, O_LD = 7'h03, O_LUI = 7'h37, O_JR = 7'h67;

  typedef struct { logic [31:0] pc; logic [31:0] alu; } trace_t;
  trace_t      exp_q[$];
  logic [31:0] prog[$];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, O_REG};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic push(input logic [31:0] p, input logic [31:0] a);
    trace_t e;
    e.pc  = p;
    e.alu = a;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    trace_t e;
    while (exp_q.size() > 0) begin
      @(negedge clk); #1;
      e = exp_q.pop_front();
      chk("pc", pc, e.pc);
      chk("alu_result", alu_result, e.alu);
    end
  endtask

  // Writes prog at word base and turns the preceding halt loop into a NOP.
  task automatic place(input int base);
    for (int i = 0; i < prog.size(); i++) dut.imem[base + i] = prog[i];
    dut.imem[base - 1] = 32'h0;
    prog.delete();
  endtask

  task automatic push_boot_trace();
    push(32'd0, 32'd0); push(32'd0, 32'd0);
    push(32'd0, 32'h12); push(32'd4, 32'd0);
    push(32'd8, 32'd12); push(32'd8, 32'd12); push(32'd8, 32'd12);
  endtask

  initial begin
    rst = 1'b1;
    #2;
    chk("rst_pc", pc, 32'd0);
    chk("rst_alu", alu_result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    chk("load_pc", pc, 32'd0);
    chk("load_alu", alu_result, 32'd0);
    push_boot_trace();
    drain();
    chk("boot_ram0", dut.data_mem.ram[0], 32'h12);

    // addi/add program, words 3..7
    prog.push_back(enc_i(32'd5, 5'd0, 3'd0, 5'd1, O_IMM));
    prog.push_back(enc_i(32'hFFFF_FFFD, 5'd0, 3'd0, 5'd2, O_IMM));
    prog.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    prog.push_back(enc_s(32'd4, 5'd3, 5'd0));
    prog.push_back(enc_j(32'd0, 5'd0));
    place(3);
    push(32'd12, 32'd5); push(32'd16, 32'hFFFF_FFFD); push(32'd20, 32'd2);
    push(32'd24, 32'd4); push(32'd28, 32'd32); push(32'd28, 32'd32);
    drain();
    chk("add_ram1", dut.data_mem.ram[1], 32'h2);

    // store/load/branch, words 8..15
    prog.push_back(enc_i(32'h55, 5'd0, 3'd0, 5'd4, O_IMM));
    prog.push_back(enc_s(32'd12, 5'd4, 5'd0));
    prog.push_back(enc_i(32'd12, 5'd0, 3'd2, 5'd5, O_LD));
    prog.push_back(enc_b(32'd8, 5'd5, 5'd4, 3'd0));
    prog.push_back(enc_s(32'd8, 5'd4, 5'd0));
    prog.push_back(enc_s(32'd16, 5'd5, 5'd0));
    prog.push_back(enc_b(32'd8, 5'd5, 5'd4, 3'd1));
    prog.push_back(enc_j(32'd0, 5'd0));
    place(8);
    push(32'd32, 32'h55); push(32'd36, 32'd12); push(32'd40, 32'd12); push(32'd44, 32'd0);
    push(32'd52, 32'd16); push(32'd56, 32'd0); push(32'd60, 32'd64); push(32'd60, 32'd64);
    drain();
    chk("beq_skip_ram2", dut.data_mem.ram[2], 32'h0);
    chk("sw_ram3", dut.data_mem.ram[3], 32'h55);
    chk("lw_ram4", dut.data_mem.ram[4], 32'h55);

    // jal/jalr and x0 writes, words 16..23
    prog.push_back(enc_j(32'd8, 5'd1));
    prog.push_back(enc_j(32'd12, 5'd0));
    prog.push_back(enc_s(32'd20, 5'd1, 5'd0));
    prog.push_back(enc_i(32'd0, 5'd1, 3'd0, 5'd6, O_JR));
    prog.push_back(enc_s(32'd24, 5'd6, 5'd0));
    prog.push_back(enc_i(32'd7, 5'd0, 3'd0, 5'd0, O_IMM));
    prog.push_back(enc_s(32'd0, 5'd0, 5'd0));
    prog.push_back(enc_j(32'd0, 5'd0));
    place(16);
    push(32'd64, 32'd68); push(32'd72, 32'd20); push(32'd76, 32'd68); push(32'd68, 32'd72);
    push(32'd80, 32'd24); push(32'd84, 32'd7); push(32'd88, 32'd0); push(32'd92, 32'd96);
    push(32'd92, 32'd96);
    drain();
    chk("jal_link_ram5", dut.data_mem.ram[5], 32'd68);
    chk("jalr_link_ram6", dut.data_mem.ram[6], 32'd80);
    chk("x0_ram0", dut.data_mem.ram[0], 32'h0);

    // ALU mix and signed branches, words 24..40
    prog.push_back(enc_i(32'hFFFF_FFF0, 5'd0, 3'd0, 5'd7, O_IMM));
    prog.push_back(enc_i(32'd2, 5'd0, 3'd0, 5'd10, O_IMM));
    prog.push_back(enc_r(7'h20, 5'd7, 5'd0, 3'd0, 5'd8));
    prog.push_back(enc_r(7'h20, 5'd10, 5'd7, 3'd5, 5'd9));
    prog.push_back(enc_r(7'h00, 5'd10, 5'd7, 3'd5, 5'd11));
    prog.push_back(enc_r(7'h00, 5'd10, 5'd8, 3'd1, 5'd12));
    prog.push_back(enc_r(7'h00, 5'd8, 5'd7, 3'd2, 5'd13));
    prog.push_back(enc_r(7'h00, 5'd8, 5'd7, 3'd3, 5'd14));
    prog.push_back(enc_r(7'h00, 5'd8, 5'd7, 3'd4, 5'd15));
    prog.push_back({20'hABCDE, 5'd16, O_LUI});
    prog.push_back(enc_i(32'h123, 5'd16, 3'd6, 5'd17, O_IMM));
    prog.push_back(enc_i(32'h0F0, 5'd17, 3'd7, 5'd18, O_IMM));
    prog.push_back(enc_b(32'd8, 5'd8, 5'd7, 3'd4));
    prog.push_back(enc_s(32'd36, 5'd17, 5'd0));
    prog.push_back(enc_b(32'd8, 5'd8, 5'd7, 3'd5));
    prog.push_back(enc_s(32'd32, 5'd17, 5'd0));
    prog.push_back(enc_j(32'd0, 5'd0));
    place(24);
    push(32'd96, 32'hFFFF_FFF0); push(32'd100, 32'd2); push(32'd104, 32'd16);
    push(32'd108, 32'hFFFF_FFFC); push(32'd112, 32'h3FFF_FFFC); push(32'd116, 32'd64);
    push(32'd120, 32'd1); push(32'd124, 32'd0); push(32'd128, 32'hFFFF_FFE0);
    push(32'd132, 32'hABCD_E000); push(32'd136, 32'hABCD_E123); push(32'd140, 32'h20);
    push(32'd144, 32'hFFFF_FFE0); push(32'd152, 32'hFFFF_FFE0); push(32'd156, 32'd32);
    push(32'd160, 32'd164); push(32'd160, 32'd164);
    drain();
    chk("ori_ram8", dut.data_mem.ram[8], 32'hABCD_E123);
    chk("blt_skip_ram9", dut.data_mem.ram[9], 32'h0);

    // reset while running: immediate clear, reload, memory retained
    rst = 1'b1;
    #1;
    chk("mid_rst_pc", pc, 32'd0);
    chk("mid_rst_alu", alu_result, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    chk("reload_pc", pc, 32'd0);
    push_boot_trace();
    drain();
    chk("reboot_ram0", dut.data_mem.ram[0], 32'h12);
    chk("keep_ram1", dut.data_mem.ram[1], 32'h2);
    chk("keep_ram8", dut.data_mem.ram[8], 32'hABCD_E123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
